can_rx_framer: RTL and testbench

CAN_RX_FRAMER -- requirements
Module: can_rx_framer

---
 rtl/can_rx_framer_pkg.sv | 21 ++
 rtl/can_rx_framer_if.sv | 32 +++
 rtl/can_rx_framer_fifo.sv | 62 ++++++
 rtl/can_rx_framer.sv | 135 +++++++++++++
 tb/tb_can_rx_framer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/can_rx_framer_pkg.sv
// Shared CAN frame definitions for the RX framer and its packet FIFO.
// Holds payload/ID sizing constants and the packed frame record that the
// assembler builds and the FIFO stores (id, ide, len, data = 98 bits).
package can_rx_framer_pkg;

  localparam int MAX_BYTES = 8;
  localparam int STD_ID_W  = 11;
  localparam int EXT_ID_W  = 29;
  localparam int LEN_W     = 4;
  localparam int DATA_W    = MAX_BYTES * 8;

  typedef struct packed {
    logic [EXT_ID_W-1:0] id;
    logic                ide;
    logic [LEN_W-1:0]    len;
    logic [DATA_W-1:0]   data;
  } can_frame_t;

  localparam int FRAME_W = $bits(can_frame_t);

endpackage

// File: rtl/can_rx_framer_if.sv
// Byte-stream input and assembled-frame output bundle of can_rx_framer.
//   in_valid/in_last/in_data/in_id/in_ide : RX byte stream from the CAN controller
//   pkt_valid/pkt_ready                    : frame handshake towards the consumer
//   pkt_id/pkt_ide/pkt_len/pkt_data        : head frame contents (show-ahead)
// slave  = the framer itself, master = whoever drives the stream / consumes frames.
interface can_rx_framer_if;
  import can_rx_framer_pkg::*;

  logic                in_valid;
  logic                in_last;
  logic [7:0]          in_data;
  logic [EXT_ID_W-1:0] in_id;
  logic                in_ide;

  logic                pkt_valid;
  logic                pkt_ready;
  logic [EXT_ID_W-1:0] pkt_id;
  logic                pkt_ide;
  logic [LEN_W-1:0]    pkt_len;
  logic [DATA_W-1:0]   pkt_data;

  modport master (
    output in_valid, in_last, in_data, in_id, in_ide, pkt_ready,
    input  pkt_valid, pkt_id, pkt_ide, pkt_len, pkt_data
  );

  modport slave (
    input  in_valid, in_last, in_data, in_id, in_ide, pkt_ready,
    output pkt_valid, pkt_id, pkt_ide, pkt_len, pkt_data
  );

endinterface

// File: rtl/can_rx_framer_fifo.sv
// can_frame_fifo: synchronous show-ahead FIFO holding assembled frames.
//   clk, rst          : clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data    : push request; wr_ok tells whether it was taken
//   full              : no free slot (a same-cycle pop still makes room)
//   rd_en             : pop request, ignored while empty
//   rd_valid, rd_data : head entry, valid whenever the FIFO is not empty
module can_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 98
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ok,
  output logic             full,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             rd_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok    = rd_en && !empty;
  // A pop in the same cycle frees the head slot, which is the one written.
  assign wr_ok    = wr_en && (!full || rd_ok);
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/can_rx_framer.sv
// can_rx_framer: assembles CAN RX byte streams into frames of 1..8 bytes and
// queues them in a show-ahead packet FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : can_rx_framer_if.slave (byte stream in, frame handshake out)
//   drop_cnt : frames lost because the FIFO was full (saturating)
//   err_cnt  : frames discarded for exceeding 8 bytes (saturating)
module can_rx_framer
  import can_rx_framer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  can_rx_framer_if.slave    bus,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [3:0]          idx_q, idx_d;
  logic                overlong_q, overlong_d;
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic [EXT_ID_W-1:0] id_q, id_d;
  logic                ide_q, ide_d;
  logic                push_q, push_d;
  can_frame_t          push_frame_q, push_frame_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0]   stage_next;
  logic [EXT_ID_W-1:0] frame_id;
  logic                frame_ide;
  logic                fifo_wr_ok;
  logic                fifo_full;
  logic                fifo_valid;
  can_frame_t          fifo_head;

  // Assembler: completed frames are registered and pushed one cycle later,
  // which leaves the byte path free to start the next frame immediately.
  always_comb begin
    idx_d        = idx_q;
    overlong_d   = overlong_q;
    stage_d      = stage_q;
    id_d         = id_q;
    ide_d        = ide_q;
    push_d       = 1'b0;
    push_frame_d = push_frame_q;
    drop_cnt_d   = drop_cnt_q;
    err_cnt_d    = err_cnt_q;
    stage_next   = stage_q;
    // The first byte's ID is taken straight from the input so a 1-byte
    // frame completes with the right ID in the same cycle it is latched.
    frame_id     = (idx_q == 4'd0) ? bus.in_id  : id_q;
    frame_ide    = (idx_q == 4'd0) ? bus.in_ide : ide_q;

    if (bus.in_valid) begin
      if (idx_q < 4'd8) begin
        stage_next[{idx_q[2:0], 3'b000} +: 8] = bus.in_data;
        if (bus.in_last) begin
          push_d            = 1'b1;
          push_frame_d.id   = frame_id;
          push_frame_d.ide  = frame_ide;
          push_frame_d.len  = idx_q + 4'd1;
          push_frame_d.data = stage_next;
          idx_d             = 4'd0;
          stage_d           = '0;
        end else begin
          idx_d   = idx_q + 4'd1;
          stage_d = stage_next;
          id_d    = frame_id;
          ide_d   = frame_ide;
        end
      end else if (bus.in_last) begin
        idx_d      = 4'd0;
        overlong_d = 1'b0;
        stage_d    = '0;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        overlong_d = 1'b1;
      end
    end

    if (push_q && !fifo_wr_ok && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      overlong_q   <= 1'b0;
      stage_q      <= '0;
      id_q         <= '0;
      ide_q        <= 1'b0;
      push_q       <= 1'b0;
      push_frame_q <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      idx_q        <= idx_d;
      overlong_q   <= overlong_d;
      stage_q      <= stage_d;
      id_q         <= id_d;
      ide_q        <= ide_d;
      push_q       <= push_d;
      push_frame_q <= push_frame_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  can_frame_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_q),
    .wr_data  (push_frame_q),
    .wr_ok    (fifo_wr_ok),
    .full     (fifo_full),
    .rd_en    (bus.pkt_ready),
    .rd_valid (fifo_valid),
    .rd_data  (fifo_head)
  );

  // FIFO storage is not reset, so the head is masked to zero while empty.
  assign bus.pkt_valid = fifo_valid;
  assign bus.pkt_id    = fifo_valid ? fifo_head.id   : '0;
  assign bus.pkt_ide   = fifo_valid ? fifo_head.ide  : 1'b0;
  assign bus.pkt_len   = fifo_valid ? fifo_head.len  : '0;
  assign bus.pkt_data  = fifo_valid ? fifo_head.data : '0;
  assign drop_cnt      = drop_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_can_rx_framer.sv
// Directed self-checking bench for can_rx_framer (DEPTH=4, CNT_W=16).
module tb_can_rx_framer;
  import can_rx_framer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  can_rx_framer_if bus ();

  can_rx_framer #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  // One comparison: counts it, and on a miss reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n bytes first, first+step, ... with the given ID; in_last on the
  // final byte only when with_last is set. Consecutive calls are back-to-back.
  task automatic applyStimulus(input logic [28:0] id, input logic ide, input int n,
                               input logic [7:0] first, input logic [7:0] step,
                               input bit with_last);
    logic [7:0] b;
    b = first;
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_id    = id;
      bus.in_ide   = ide;
      bus.in_data  = b;
      bus.in_last  = with_last && (k == n - 1);
      tick();
      b = b + step;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pop();
    bus.pkt_ready = 1'b1;
    tick();
    bus.pkt_ready = 1'b0;
  endtask

  function automatic logic [63:0] exp_data(input int n, input logic [7:0] first,
                                           input logic [7:0] step);
    logic [63:0] d;
    logic [7:0]  b;
    d = '0;
    b = first;
    for (int k = 0; k < n; k++) begin
      d[k*8 +: 8] = b;
      b = b + step;
    end
    return d;
  endfunction

  task automatic check_frame(input string tag, input logic [28:0] id, input logic ide,
                             input logic [3:0] len, input logic [63:0] data);
    checkOutput({tag, ".valid"}, 64'(bus.pkt_valid), 64'd1);
    checkOutput({tag, ".id"},    64'(bus.pkt_id),    64'(id));
    checkOutput({tag, ".ide"},   64'(bus.pkt_ide),   64'(ide));
    checkOutput({tag, ".len"},   64'(bus.pkt_len),   64'(len));
    checkOutput({tag, ".data"},  bus.pkt_data,       data);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.in_id     = '0;
    bus.in_ide    = 1'b0;
    bus.pkt_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst.valid", 64'(bus.pkt_valid), 64'd0);
    checkOutput("rst.id",    64'(bus.pkt_id),    64'd0);
    checkOutput("rst.len",   64'(bus.pkt_len),   64'd0);
    checkOutput("rst.data",  bus.pkt_data,       64'd0);
    checkOutput("rst.drop",  64'(drop_cnt),      64'd0);
    checkOutput("rst.err",   64'(err_cnt),       64'd0);
    rst = 1'b0;
    tick();

    // Short standard frame, two-cycle latency from in_last to pkt_valid.
    applyStimulus(29'h123, 1'b0, 3, 8'h11, 8'h11, 1'b1);
    checkOutput("single.early", 64'(bus.pkt_valid), 64'd0);
    tick();
    check_frame("single", 29'h123, 1'b0, 4'd3, 64'h0000_0000_0033_2211);
    pop();
    checkOutput("single.popped", 64'(bus.pkt_valid), 64'd0);

    // Extended ID with a full 8-byte payload.
    applyStimulus(29'h1234_5678, 1'b1, 8, 8'h01, 8'h01, 1'b1);
    tick();
    check_frame("long", 29'h1234_5678, 1'b1, 4'd8, 64'h0807_0605_0403_0201);
    pop();

    // Ready while empty must not disturb anything.
    pop();
    checkOutput("emptypop.valid", 64'(bus.pkt_valid), 64'd0);

    // Ten-byte packet is discarded; the next short frame comes out clean.
    applyStimulus(29'h0AA, 1'b0, 10, 8'hA0, 8'h01, 1'b1);
    tick();
    tick();
    checkOutput("over.valid", 64'(bus.pkt_valid), 64'd0);
    checkOutput("over.err",   64'(err_cnt),       64'd1);
    checkOutput("over.drop",  64'(drop_cnt),      64'd0);
    applyStimulus(29'h055, 1'b0, 2, 8'h5A, 8'h01, 1'b1);
    tick();
    check_frame("after_over", 29'h055, 1'b0, 4'd2, 64'h0000_0000_0000_5B5A);
    pop();

    // Four back-to-back frames fill the FIFO; a fifth is dropped.
    for (int f = 1; f <= 4; f++)
      applyStimulus(29'(32'h100 + f), 1'b0, 8, 8'(f * 16), 8'h01, 1'b1);
    applyStimulus(29'h105, 1'b0, 8, 8'h50, 8'h01, 1'b1);
    tick();
    tick();
    checkOutput("full.drop", 64'(drop_cnt), 64'd1);
    check_frame("full.head", 29'h101, 1'b0, 4'd8, exp_data(8, 8'h10, 8'h01));

    // A sixth frame pushed while full, in the same cycle as a pop, is kept.
    applyStimulus(29'h106, 1'b0, 8, 8'h60, 8'h01, 1'b1);
    bus.pkt_ready = 1'b1;
    tick();
    bus.pkt_ready = 1'b0;
    checkOutput("pushpop.drop", 64'(drop_cnt), 64'd1);
    check_frame("order2", 29'h102, 1'b0, 4'd8, exp_data(8, 8'h20, 8'h01));
    pop();
    check_frame("order3", 29'h103, 1'b0, 4'd8, exp_data(8, 8'h30, 8'h01));
    pop();
    check_frame("order4", 29'h104, 1'b0, 4'd8, exp_data(8, 8'h40, 8'h01));
    pop();
    check_frame("order6", 29'h106, 1'b0, 4'd8, exp_data(8, 8'h60, 8'h01));
    pop();
    checkOutput("drained.valid", 64'(bus.pkt_valid), 64'd0);

    // Reset with a queued frame and a half-received one.
    applyStimulus(29'h321, 1'b0, 2, 8'h70, 8'h01, 1'b1);
    tick();
    checkOutput("prerst.valid", 64'(bus.pkt_valid), 64'd1);
    applyStimulus(29'h322, 1'b0, 5, 8'h80, 8'h01, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst.valid", 64'(bus.pkt_valid), 64'd0);
    checkOutput("midrst.id",    64'(bus.pkt_id),    64'd0);
    checkOutput("midrst.len",   64'(bus.pkt_len),   64'd0);
    checkOutput("midrst.data",  bus.pkt_data,       64'd0);
    checkOutput("midrst.drop",  64'(drop_cnt),      64'd0);
    checkOutput("midrst.err",   64'(err_cnt),       64'd0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(29'h2AB, 1'b0, 1, 8'hAB, 8'h01, 1'b1);
    checkOutput("postrst.early", 64'(bus.pkt_valid), 64'd0);
    tick();
    check_frame("postrst", 29'h2AB, 1'b0, 4'd1, 64'h0000_0000_0000_00AB);
    checkOutput("postrst.drop", 64'(drop_cnt), 64'd0);
    checkOutput("postrst.err",  64'(err_cnt),  64'd0);
    pop();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
